// File: rtl/square_seq.sv
// square_seq: sequential integer squarer.
// Computes out_data = |in_data|^2 by radix-2 shift-add, one operand bit per clock.
// Valid/ready handshakes on both sides. Only one operation is in flight at a time:
// an operand is accepted in IDLE, processed in CALC over WIDTH cycles, and then
// held in DONE until the consumer takes the result.
module square_seq #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_data
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [2*WIDTH-1:0] out_data_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   op_q;
    logic [CW-1:0]      count_q;

    logic [WIDTH-1:0]   mag_d;
    logic [2*WIDTH-1:0] addend_d;
    logic [2*WIDTH-1:0] acc_d;

    // Unsigned magnitude of the incoming operand. It is only captured on an
    // accepted handshake, so in_data is never sampled while in_valid is low.
    // NOTE: every output of an always_comb gets a default first; a path that
    // leaves it unassigned would infer a latch.
    always_comb begin
        mag_d = in_data;
        if (SIGNED && in_data[WIDTH-1]) begin
            mag_d = -in_data;
        end
    end

    // Partial product for the current bit: op << count when op[count] is set.
    // The running sum is 2*WIDTH bits wide, so it can never overflow.
    always_comb begin
        addend_d = '0;
        if (op_q[count_q]) begin
            addend_d = {{WIDTH{1'b0}}, op_q} << count_q;
        end
        acc_d = acc_q + addend_d;
    end

    // Control FSM and datapath registers. All outputs are registered.
    // NOTE: the datapath registers are reset too. An operation that is aborted
    // by reset must leave out_data at zero, not at a stale result.
    // NOTE: state is updated only with non-blocking assignments. Every read in
    // this block then sees the value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
            op_q        <= '0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        op_q       <= mag_d;
                        acc_q      <= '0;
                        count_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    if (count_q == LAST) begin
                        // The last bit is folded straight into the published result.
                        out_data_q  <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                DONE: begin
                    // Hold the result under backpressure. in_ready stays low
                    // here, so a new operand can never be accepted in the
                    // same cycle as the output handshake.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_square_seq.sv
// Testbench for square_seq. It drives two instances: one unsigned and one signed.
// Stimulus pushes the expected square into a per-instance queue. A monitor for
// each instance pops an entry and compares it whenever an output handshake occurs.
module tb_square_seq;

    localparam int W  = 32;
    localparam int W2 = 2 * W;

    typedef struct {
        logic [W2-1:0] exp;
        logic [W-1:0]  op;
        int unsigned   t_acc;
    } item_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;

    logic          in_valid_u = 1'b0, in_ready_u, out_valid_u, out_ready_u = 1'b1;
    logic [W-1:0]  in_data_u  = '0;
    logic [W2-1:0] out_data_u;
    logic          in_valid_s = 1'b0, in_ready_s, out_valid_s, out_ready_s = 1'b1;
    logic [W-1:0]  in_data_s  = '0;
    logic [W2-1:0] out_data_s;

    int unsigned   cyc      = 0;
    int            n_pass   = 0;
    int            n_total  = 0;
    int            rdy_mode = 0;   // 0: always ready, 1: hold off, 2: random
    item_t         q_u[$];
    item_t         q_s[$];

    square_seq #(.WIDTH(W), .SIGNED(1'b0)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_u),
        .in_ready  (in_ready_u),
        .in_data   (in_data_u),
        .out_valid (out_valid_u),
        .out_ready (out_ready_u),
        .out_data  (out_data_u)
    );

    square_seq #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready_s),
        .in_data   (in_data_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready_s),
        .out_data  (out_data_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the square of the operand's magnitude, computed with plain 64-bit arithmetic.
    function automatic logic [W2-1:0] model_sq(input logic [W-1:0] d, input bit signed_mode);
        logic [W2-1:0] m;
        longint        v;
        v = longint'($signed(d));
        if (signed_mode) begin
            if (v < 0) v = -v;
            m = W2'(v);
        end else begin
            m = {{W{1'b0}}, d};
        end
        return m * m;
    endfunction

    // Integer square root by bitwise search. It cross-checks a result independently.
    function automatic logic [W-1:0] isqrt(input logic [W2-1:0] x);
        logic [W2-1:0] r, t;
        r = '0;
        for (int b = W - 1; b >= 0; b--) begin
            t = r | (W2'(1) << b);
            if (t * t <= x) r = t;
        end
        return r[W-1:0];
    endfunction

    task automatic check(input string name, input logic [W2-1:0] act, input logic [W2-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Present one operand to an instance and wait until it is accepted.
    // Then push the expected square to that instance's queue.
    task automatic send(input bit to_s, input logic [W-1:0] d, output int unsigned t_acc);
        int    n;
        item_t it;
        n = 0;
        t_acc = cyc;
        @(posedge clk); #1;
        while (!(to_s ? in_ready_s : in_ready_u) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            check(to_s ? "in_ready_timeout_s" : "in_ready_timeout_u",
                  W2'(to_s ? in_ready_s : in_ready_u), 1);
            return;
        end
        if (to_s) begin in_valid_s = 1'b1; in_data_s = d; end
        else      begin in_valid_u = 1'b1; in_data_u = d; end
        @(posedge clk); #1;
        t_acc    = cyc;
        it.exp   = model_sq(d, to_s);
        it.op    = d;
        it.t_acc = cyc;
        if (to_s) begin q_s.push_back(it); in_valid_s = 1'b0; in_data_s = $urandom; end
        else      begin q_u.push_back(it); in_valid_u = 1'b0; in_data_u = $urandom; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_u.size() != 0 || q_s.size() != 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 5000) check("drain_timeout", W2'(q_u.size() + q_s.size()), 0);
        @(posedge clk); #1;
    endtask

    // Consumer backpressure generator.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       begin out_ready_u = 1'b1; out_ready_s = 1'b1; end
                1:       begin out_ready_u = 1'b0; out_ready_s = 1'b0; end
                default: begin out_ready_u = 1'($urandom); out_ready_s = 1'($urandom); end
            endcase
        end
    end

    // Monitor for the unsigned instance: latency at the rise of out_valid, then data and sqrt at the handshake.
    logic ov_prev_u = 1'b0;
    always @(negedge clk) begin
        item_t it;
        if (!rst_n) ov_prev_u = 1'b0;
        else begin
            if (out_valid_u && !ov_prev_u) begin
                if (q_u.size() == 0) check("spurious_out_valid_u", W2'(out_valid_u), 0);
                else                 check("latency_u", W2'(cyc - q_u[0].t_acc), W);
            end
            if (out_valid_u && out_ready_u) begin
                if (q_u.size() == 0) check("unexpected_result_u", W2'(out_valid_u), 0);
                else begin
                    it = q_u.pop_front();
                    check("square_u", out_data_u, it.exp);
                    check("isqrt_u", W2'(isqrt(out_data_u)), W2'(it.op));
                end
            end
            ov_prev_u = out_valid_u;
        end
    end

    // Monitor for the signed instance.
    logic ov_prev_s = 1'b0;
    always @(negedge clk) begin
        item_t it;
        if (!rst_n) ov_prev_s = 1'b0;
        else begin
            if (out_valid_s && !ov_prev_s) begin
                if (q_s.size() == 0) check("spurious_out_valid_s", W2'(out_valid_s), 0);
                else                 check("latency_s", W2'(cyc - q_s[0].t_acc), W);
            end
            if (out_valid_s && out_ready_s) begin
                if (q_s.size() == 0) check("unexpected_result_s", W2'(out_valid_s), 0);
                else begin
                    it = q_s.pop_front();
                    check("square_s", out_data_s, it.exp);
                end
            end
            ov_prev_s = out_valid_s;
        end
    end

    // Watchdog: ends the run if the sequence below ever stalls.
    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int unsigned t, t_prev;
        logic [W2-1:0] e;
        int n;

        // Values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready_u",  W2'(in_ready_u),  0);
        check("rst_out_valid_u", W2'(out_valid_u), 0);
        check("rst_out_data_u",  out_data_u,       0);
        check("rst_in_ready_s",  W2'(in_ready_s),  0);
        check("rst_out_valid_s", W2'(out_valid_s), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_first_edge", W2'(in_ready_u), 0);
        @(posedge clk); #1;
        check("in_ready_after_first_edge", W2'(in_ready_u), 1);

        // Directed corner values.
        send(1'b0, 32'd0, t);
        send(1'b0, 32'd1, t);
        send(1'b0, 32'd65535, t);
        send(1'b0, 32'hFFFF_FFFF, t);
        send(1'b1, 32'hFFFF_FFFD, t);
        send(1'b1, 32'h8000_0000, t);
        send(1'b1, 32'h7FFF_FFFF, t);
        send(1'b1, 32'hFFFF_FFFF, t);
        drain();

        // Random operands under random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            send(1'b0, $urandom, t);
            send(1'b1, $urandom, t);
        end
        drain();

        // Hold out_ready low and drive spurious in_valid pulses in CALC and DONE.
        rdy_mode = 1;
        @(posedge clk); #1;
        e = model_sq(32'h0001_2345, 1'b0);
        send(1'b0, 32'h0001_2345, t);
        in_valid_u = 1'b1;
        in_data_u  = 32'hDEAD_BEEF;
        n = 0;
        while (!out_valid_u && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 5) check("calc_in_ready_low", W2'(in_ready_u), 0);
        end
        check("bp_out_valid_rise", W2'(out_valid_u), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_data_u = $urandom;
            check("bp_out_valid_hold", W2'(out_valid_u), 1);
            check("bp_out_data_hold",  out_data_u,       e);
            check("bp_in_ready_low",   W2'(in_ready_u),  0);
        end
        in_valid_u = 1'b0;
        rdy_mode = 0;
        drain();

        // Assert reset asynchronously in the middle of CALC, when count is 15.
        send(1'b0, 32'd40000, t);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", W2'(out_valid_u), 0);
        check("async_rst_out_data",  out_data_u,       0);
        check("async_rst_in_ready",  W2'(in_ready_u),  0);
        if (q_u.size() != 0) void'(q_u.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", W2'(in_ready_u), 1);
        send(1'b0, 32'd7, t);
        drain();
        check("post_rst_last_result", out_data_u, 64'd49);

        // Back-to-back sweep with the consumer always ready.
        // Each accept must come exactly WIDTH+2 cycles after the previous one.
        t_prev = 0;
        for (int s = 0; s < 1024; s++) begin
            send(1'b0, W'(s), t);
            if (s > 0) check("initiation_interval", W2'(t - t_prev), W + 2);
            t_prev = t;
        end
        for (int i = 0; i < 64; i++) begin
            send(1'b0, W'($urandom_range(4095, 1024)), t);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
